// File: rtl/vend_controller.sv
// Vending dispense sequencer: accumulates coin credit in nickels, hands a key to the
// dispense unit, applies its charge strobes and returns leftover credit via refund handshake.
`timescale 1ns/1ps

module vend_controller #(
    parameter int unsigned CREDIT_MAX  = 63,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       coin_25,
    input  logic [3:0] key_code,
    input  logic       key_rdy,
    input  logic       cancel,
    input  logic       disp_done,
    input  logic       disp_failed,
    input  logic       disp_down_5,
    input  logic       disp_down_10,
    input  logic       disp_down_25,
    output logic       disp_enable,
    output logic [3:0] disp_key,
    output logic [5:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       key_err,
    output logic       refund_valid,
    output logic [5:0] refund_val,
    input  logic       refund_ack
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_REFUND   = 2'd3
    } state_t;

    localparam logic [6:0]  CREDIT_MAX_W = 7'(CREDIT_MAX);
    // Timer reaches TIMEOUT_CYC on the edge where it would step past this value.
    localparam logic [15:0] TIMER_LAST   = 16'(TIMEOUT_CYC - 1);

    function automatic logic [3:0] coin_add(input logic c5, input logic c10, input logic c25);
        logic [3:0] sum;
        sum = {3'd0, c5} + {2'd0, c10, 1'b0} + (c25 ? 4'd5 : 4'd0);
        return sum;
    endfunction

    function automatic logic [2:0] charge_of(input logic d5, input logic d10, input logic d25);
        logic [2:0] chg;
        if (d25) begin
            chg = 3'd5;
        end else if (d10) begin
            chg = 3'd2;
        end else if (d5) begin
            chg = 3'd1;
        end else begin
            chg = 3'd0;
        end
        return chg;
    endfunction

    function automatic logic [5:0] sat_sub(input logic [5:0] a, input logic [2:0] b);
        logic [5:0] res;
        if (a > {3'd0, b}) begin
            res = a - {3'd0, b};
        end else begin
            res = 6'd0;
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  credit_q, credit_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  key_q, key_d;
    logic        coin_reject_q, coin_reject_d;
    logic        key_err_q, key_err_d;
    logic        disp_enable_q, busy_q, refund_valid_q;
    logic [5:0]  refund_val_q;

    logic [3:0]  add_s;
    logic [6:0]  sum_s;
    logic        coin_any_s;
    logic        coin_fit_s;
    logic [5:0]  credit_ded_s;
    logic        key_ok_s;
    logic        timeout_s;

    // Shared arithmetic and decode terms for the next-state logic.
    always_comb begin
        add_s        = coin_add(coin_5, coin_10, coin_25);
        sum_s        = {1'b0, credit_q} + {3'd0, add_s};
        coin_any_s   = coin_5 | coin_10 | coin_25;
        coin_fit_s   = (sum_s <= CREDIT_MAX_W);
        credit_ded_s = sat_sub(credit_q, charge_of(disp_down_5, disp_down_10, disp_down_25));
        key_ok_s     = (key_code != 4'd0) && (key_code <= 4'd8);
        timeout_s    = (timer_q >= TIMER_LAST);
    end

    // Next-state, credit, timer and key-latch logic.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = timer_q;
        key_d         = key_q;
        coin_reject_d = 1'b0;
        key_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                credit_d = 6'd0;
                timer_d  = 16'd0;
                key_d    = 4'd0;
                if (coin_any_s) begin
                    if (coin_fit_s) begin
                        credit_d = sum_s[5:0];
                        state_d  = S_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CREDIT: begin
                if (coin_any_s) begin
                    if (coin_fit_s) begin
                        credit_d = sum_s[5:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else begin
                    credit_d = credit_q;
                end

                if (cancel) begin
                    state_d = S_REFUND;
                    timer_d = 16'd0;
                end else if (key_rdy) begin
                    timer_d = 16'd0;
                    if (key_ok_s) begin
                        key_d   = key_code;
                        state_d = S_DISPENSE;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (coin_any_s && coin_fit_s) begin
                    timer_d = 16'd0;
                end else if (timeout_s) begin
                    state_d = S_REFUND;
                    timer_d = 16'd0;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            S_DISPENSE: begin
                coin_reject_d = coin_any_s;
                if (disp_failed) begin
                    state_d = S_REFUND;
                    timer_d = 16'd0;
                end else begin
                    credit_d = credit_ded_s;
                    if (disp_done) begin
                        timer_d = 16'd0;
                        if (credit_ded_s != 6'd0) begin
                            state_d = S_REFUND;
                        end else begin
                            state_d = S_IDLE;
                            key_d   = 4'd0;
                        end
                    end else if (timeout_s) begin
                        state_d = S_REFUND;
                        timer_d = 16'd0;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end

            S_REFUND: begin
                coin_reject_d = coin_any_s;
                if (refund_ack) begin
                    credit_d = 6'd0;
                    key_d    = 4'd0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_REFUND;
                end
            end

            default: begin
                state_d  = S_IDLE;
                credit_d = 6'd0;
                timer_d  = 16'd0;
                key_d    = 4'd0;
            end
        endcase
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            credit_q       <= 6'd0;
            timer_q        <= 16'd0;
            key_q          <= 4'd0;
            coin_reject_q  <= 1'b0;
            key_err_q      <= 1'b0;
            disp_enable_q  <= 1'b0;
            busy_q         <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_val_q   <= 6'd0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            key_q          <= key_d;
            coin_reject_q  <= coin_reject_d;
            key_err_q      <= key_err_d;
            disp_enable_q  <= (state_d == S_DISPENSE);
            busy_q         <= (state_d != S_IDLE);
            refund_valid_q <= (state_d == S_REFUND);
            refund_val_q   <= (state_d == S_REFUND) ? credit_d : 6'd0;
        end
    end

    assign disp_enable  = disp_enable_q;
    assign disp_key     = key_q;
    assign credit       = credit_q;
    assign busy         = busy_q;
    assign coin_reject  = coin_reject_q;
    assign key_err      = key_err_q;
    assign refund_valid = refund_valid_q;
    assign refund_val   = refund_val_q;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus randomized traffic
// compared against a behavioural credit/mode model.
`timescale 1ns/1ps

module tb_vend_controller;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       coin_5, coin_10, coin_25;
    logic [3:0] key_code;
    logic       key_rdy, cancel, disp_done, disp_failed;
    logic       disp_down_5, disp_down_10, disp_down_25;
    logic       disp_enable;
    logic [3:0] disp_key;
    logic [5:0] credit;
    logic       busy, coin_reject, key_err, refund_valid;
    logic [5:0] refund_val;
    logic       refund_ack;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0 idle, 1 collecting, 2 dispensing, 3 refunding.
    int m_mode, m_credit, m_timer, m_key;
    bit e_reject, e_keyerr;

    vend_controller #(.CREDIT_MAX(63), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
        .key_code(key_code), .key_rdy(key_rdy), .cancel(cancel),
        .disp_done(disp_done), .disp_failed(disp_failed),
        .disp_down_5(disp_down_5), .disp_down_10(disp_down_10), .disp_down_25(disp_down_25),
        .disp_enable(disp_enable), .disp_key(disp_key), .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .key_err(key_err),
        .refund_valid(refund_valid), .refund_val(refund_val), .refund_ack(refund_ack)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        coin_5 = 1'b0; coin_10 = 1'b0; coin_25 = 1'b0;
        key_code = 4'd0; key_rdy = 1'b0; cancel = 1'b0;
        disp_done = 1'b0; disp_failed = 1'b0;
        disp_down_5 = 1'b0; disp_down_10 = 1'b0; disp_down_25 = 1'b0;
        refund_ack = 1'b0;
    endtask

    task automatic pulse_coin(input bit c5, input bit c10, input bit c25);
        coin_5 = c5; coin_10 = c10; coin_25 = c25;
        cyc();
        coin_5 = 1'b0; coin_10 = 1'b0; coin_25 = 1'b0;
    endtask

    task automatic press_key(input logic [3:0] k);
        key_code = k; key_rdy = 1'b1;
        cyc();
        key_rdy = 1'b0;
    endtask

    task automatic do_ack();
        refund_ack = 1'b1;
        cyc();
        refund_ack = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        #13;
        checks++;
        if ({disp_enable, disp_key, credit, busy, coin_reject, key_err, refund_valid, refund_val} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                {disp_enable, disp_key, credit, busy, coin_reject, key_err, refund_valid, refund_val});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b credit=%0d expected busy=0 credit=0", busy, credit);
        end
    endtask

    task automatic test_coin_and_key();
        pulse_coin(0, 0, 1);
        checks++;
        if (credit !== 6'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_quarter: credit=%0d busy=%b expected 5/1", credit, busy);
        end
        pulse_coin(0, 1, 0);
        checks++;
        if (credit !== 6'd7) begin
            errors++;
            $display("FAIL t1_dime: credit=%0d expected 7", credit);
        end
        press_key(4'd3);
        checks++;
        if (disp_enable !== 1'b1 || disp_key !== 4'd3 || credit !== 6'd7) begin
            errors++;
            $display("FAIL t1_key: en=%b key=%0d credit=%0d expected 1/3/7", disp_enable, disp_key, credit);
        end
        disp_down_10 = 1'b1;
        cyc();
        disp_down_10 = 1'b0;
        checks++;
        if (credit !== 6'd5 || disp_enable !== 1'b1) begin
            errors++;
            $display("FAIL t1_down10: credit=%0d en=%b expected 5/1", credit, disp_enable);
        end
        disp_failed = 1'b1;
        cyc();
        disp_failed = 1'b0;
        checks++;
        if (refund_valid !== 1'b1 || refund_val !== 6'd5 || disp_enable !== 1'b0) begin
            errors++;
            $display("FAIL t1_refund: rv=%b val=%0d en=%b expected 1/5/0", refund_valid, refund_val, disp_enable);
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0 || disp_key !== 4'd0 || refund_valid !== 1'b0) begin
            errors++;
            $display("FAIL t1_ack: busy=%b credit=%0d key=%0d rv=%b expected all 0", busy, credit, disp_key, refund_valid);
        end
    endtask

    task automatic test_overflow();
        repeat (12) pulse_coin(0, 0, 1);
        checks++;
        if (credit !== 6'd60) begin
            errors++;
            $display("FAIL t2_fill: credit=%0d expected 60", credit);
        end
        pulse_coin(0, 0, 1);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd60) begin
            errors++;
            $display("FAIL t2_reject: rej=%b credit=%0d expected 1/60", coin_reject, credit);
        end
        cyc();
        checks++;
        if (coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL t2_reject_pulse: rej=%b expected 0", coin_reject);
        end
        pulse_coin(1, 0, 0);
        checks++;
        if (credit !== 6'd61) begin
            errors++;
            $display("FAIL t2_nickel: credit=%0d expected 61", credit);
        end
        pulse_coin(0, 1, 0);
        checks++;
        if (credit !== 6'd63 || coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL t2_exact_max: credit=%0d rej=%b expected 63/0", credit, coin_reject);
        end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        checks++;
        if (refund_valid !== 1'b1 || refund_val !== 6'd63) begin
            errors++;
            $display("FAIL t2_cancel: rv=%b val=%0d expected 1/63", refund_valid, refund_val);
        end
        do_ack();
    endtask

    task automatic test_bad_key();
        pulse_coin(1, 1, 1);
        checks++;
        if (credit !== 6'd8) begin
            errors++;
            $display("FAIL t3_sum: credit=%0d expected 8", credit);
        end
        press_key(4'd9);
        checks++;
        if (key_err !== 1'b1 || busy !== 1'b1 || disp_enable !== 1'b0 || credit !== 6'd8) begin
            errors++;
            $display("FAIL t3_key9: err=%b busy=%b en=%b credit=%0d expected 1/1/0/8", key_err, busy, disp_enable, credit);
        end
        cyc();
        checks++;
        if (key_err !== 1'b0) begin
            errors++;
            $display("FAIL t3_err_pulse: err=%b expected 0", key_err);
        end
        press_key(4'd0);
        checks++;
        if (key_err !== 1'b1 || disp_enable !== 1'b0) begin
            errors++;
            $display("FAIL t3_key0: err=%b en=%b expected 1/0", key_err, disp_enable);
        end
        press_key(4'd8);
        checks++;
        if (disp_enable !== 1'b1 || disp_key !== 4'd8 || key_err !== 1'b0) begin
            errors++;
            $display("FAIL t3_key8: en=%b key=%0d err=%b expected 1/8/0", disp_enable, disp_key, key_err);
        end
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        checks++;
        if (refund_valid !== 1'b0 || disp_enable !== 1'b1) begin
            errors++;
            $display("FAIL t3_cancel_ignored: rv=%b en=%b expected 0/1", refund_valid, disp_enable);
        end
        pulse_coin(1, 0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 6'd8) begin
            errors++;
            $display("FAIL t3_coin_in_dispense: rej=%b credit=%0d expected 1/8", coin_reject, credit);
        end
        disp_failed = 1'b1;
        cyc();
        disp_failed = 1'b0;
        do_ack();
    endtask

    task automatic test_dispense_done();
        repeat (3) pulse_coin(0, 0, 1);
        press_key(4'd1);
        disp_down_25 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++;
            if (credit !== 6'(15 - 5 * i)) begin
                errors++;
                $display("FAIL t4_deduct_%0d: credit=%0d expected %0d", i, credit, 15 - 5 * i);
            end
        end
        disp_down_25 = 1'b0;
        disp_down_5 = 1'b1;
        cyc();
        disp_down_5 = 1'b0;
        checks++;
        if (credit !== 6'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t4_saturate: credit=%0d busy=%b expected 0/1", credit, busy);
        end
        disp_done = 1'b1;
        cyc();
        disp_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || refund_valid !== 1'b0 || disp_enable !== 1'b0) begin
            errors++;
            $display("FAIL t4_done_idle: busy=%b rv=%b en=%b expected 0/0/0", busy, refund_valid, disp_enable);
        end
        repeat (3) pulse_coin(0, 0, 1);
        pulse_coin(0, 1, 0);
        press_key(4'd1);
        disp_down_25 = 1'b1;
        repeat (3) cyc();
        disp_down_25 = 1'b0;
        disp_done = 1'b1;
        cyc();
        disp_done = 1'b0;
        checks++;
        if (refund_valid !== 1'b1 || refund_val !== 6'd2) begin
            errors++;
            $display("FAIL t4_done_refund: rv=%b val=%0d expected 1/2", refund_valid, refund_val);
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || refund_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_ack: busy=%b rv=%b expected 0/0", busy, refund_valid);
        end
    endtask

    task automatic test_failed_hold();
        pulse_coin(0, 0, 1);
        press_key(4'd5);
        disp_failed = 1'b1;
        disp_down_25 = 1'b1;
        cyc();
        disp_failed = 1'b0;
        disp_down_25 = 1'b0;
        checks++;
        if (refund_valid !== 1'b1 || refund_val !== 6'd5 || credit !== 6'd5) begin
            errors++;
            $display("FAIL t5_failed: rv=%b val=%0d credit=%0d expected 1/5/5", refund_valid, refund_val, credit);
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (refund_valid !== 1'b1 || refund_val !== 6'd5) begin
                errors++;
                $display("FAIL t5_hold_%0d: rv=%b val=%0d expected 1/5", i, refund_valid, refund_val);
            end
        end
        do_ack();
        checks++;
        if (busy !== 1'b0 || refund_valid !== 1'b0 || refund_val !== 6'd0) begin
            errors++;
            $display("FAIL t5_ack: busy=%b rv=%b val=%0d expected 0/0/0", busy, refund_valid, refund_val);
        end
    endtask

    task automatic test_timeout_and_reset();
        pulse_coin(0, 1, 0);
        pulse_coin(0, 1, 0);
        for (int i = 1; i < TO; i++) begin
            cyc();
            checks++;
            if (refund_valid !== 1'b0) begin
                errors++;
                $display("FAIL t6_early_timeout_%0d: rv=%b expected 0", i, refund_valid);
            end
        end
        cyc();
        checks++;
        if (refund_valid !== 1'b1 || refund_val !== 6'd4) begin
            errors++;
            $display("FAIL t6_timeout: rv=%b val=%0d expected 1/4", refund_valid, refund_val);
        end
        do_ack();
        do_ack();
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL t6_ack_in_idle: busy=%b credit=%0d expected 0/0", busy, credit);
        end
        pulse_coin(0, 0, 1);
        press_key(4'd2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({disp_enable, disp_key, credit, busy, coin_reject, key_err, refund_valid, refund_val} !== 21'd0) begin
            errors++;
            $display("FAIL t6_async_reset: got %b expected all zero",
                {disp_enable, disp_key, credit, busy, coin_reject, key_err, refund_valid, refund_val});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || credit !== 6'd0) begin
            errors++;
            $display("FAIL t6_after_reset: busy=%b credit=%0d expected 0/0", busy, credit);
        end
    endtask

    task automatic model_update();
        int add;
        int chg;
        bit any;
        bit took;
        add = int'(coin_5) + 2 * int'(coin_10) + 5 * int'(coin_25);
        any = coin_5 | coin_10 | coin_25;
        took = 1'b0;
        e_reject = 1'b0;
        e_keyerr = 1'b0;
        case (m_mode)
            0: begin
                if (any && add <= 63) begin
                    m_credit = add; m_mode = 1; m_timer = 0;
                end else if (any) begin
                    e_reject = 1'b1;
                end
            end
            1: begin
                if (any && m_credit + add <= 63) begin
                    m_credit = m_credit + add; took = 1'b1;
                end else if (any) begin
                    e_reject = 1'b1;
                end
                if (cancel) begin
                    m_mode = 3;
                end else if (key_rdy) begin
                    m_timer = 0;
                    if (key_code >= 1 && key_code <= 8) begin
                        m_key = int'(key_code); m_mode = 2;
                    end else begin
                        e_keyerr = 1'b1;
                    end
                end else if (took) begin
                    m_timer = 0;
                end else begin
                    m_timer++;
                    if (m_timer == TO) m_mode = 3;
                end
            end
            2: begin
                e_reject = any;
                if (disp_failed) begin
                    m_mode = 3;
                end else begin
                    chg = disp_down_25 ? 5 : (disp_down_10 ? 2 : (disp_down_5 ? 1 : 0));
                    m_credit = (m_credit - chg < 0) ? 0 : m_credit - chg;
                    if (disp_done) begin
                        if (m_credit > 0) m_mode = 3;
                        else begin m_mode = 0; m_key = 0; end
                    end else begin
                        m_timer++;
                        if (m_timer == TO) m_mode = 3;
                    end
                end
            end
            3: begin
                e_reject = any;
                if (refund_ack) begin
                    m_mode = 0; m_credit = 0; m_key = 0;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic test_random();
        int act;
        clear_inputs();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_mode = 0; m_credit = 0; m_timer = 0; m_key = 0;
        act = 2;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) act = $urandom_range(0, 3);
            coin_5  = ($urandom_range(0, 19) < act);
            coin_10 = ($urandom_range(0, 19) < act);
            coin_25 = ($urandom_range(0, 19) < act);
            key_code = 4'($urandom_range(0, 15));
            key_rdy = (act > 0) && ($urandom_range(0, (act == 3) ? 59 : 11) == 0);
            cancel = ($urandom_range(0, 39) == 0);
            disp_down_5  = ($urandom_range(0, 2) == 0);
            disp_down_10 = ($urandom_range(0, 2) == 0);
            disp_down_25 = ($urandom_range(0, 2) == 0);
            disp_done   = ($urandom_range(0, 11) == 0);
            disp_failed = ($urandom_range(0, 39) == 0);
            refund_ack  = ($urandom_range(0, 3) == 0);
            cyc();
            model_update();
            checks++;
            if (credit !== 6'(m_credit) || busy !== (m_mode != 0)) begin
                errors++;
                $display("FAIL rnd_credit_busy @%0d: credit=%0d busy=%b expected %0d/%0b", n, credit, busy, m_credit, m_mode != 0);
            end
            checks++;
            if (disp_enable !== (m_mode == 2) || disp_key !== 4'(m_key)) begin
                errors++;
                $display("FAIL rnd_dispense @%0d: en=%b key=%0d expected %0b/%0d", n, disp_enable, disp_key, m_mode == 2, m_key);
            end
            checks++;
            if (refund_valid !== (m_mode == 3) || refund_val !== ((m_mode == 3) ? 6'(m_credit) : 6'd0)) begin
                errors++;
                $display("FAIL rnd_refund @%0d: rv=%b val=%0d expected %0b/%0d", n, refund_valid, refund_val, m_mode == 3, (m_mode == 3) ? m_credit : 0);
            end
            checks++;
            if (coin_reject !== e_reject || key_err !== e_keyerr) begin
                errors++;
                $display("FAIL rnd_pulses @%0d: rej=%b err=%b expected %b/%b", n, coin_reject, key_err, e_reject, e_keyerr);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_coin_and_key();
        test_overflow();
        test_bad_key();
        test_dispense_done();
        test_failed_hold();
        test_timeout_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
